// File: rtl/cla_group_sequencer.sv
// Multi-cycle adder: one GROUP-bit carry-lookahead slice is evaluated per clock.
// Optional macro CLA_OVERFLOW_EN adds a registered signed-overflow output (ovf).
module cla_group_sequencer #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
`ifdef CLA_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    localparam int N  = WIDTH / GROUP;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state;
    logic [KW-1:0]    k;
    logic             carry;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;

    logic [GROUP-1:0] ga;
    logic [GROUP-1:0] gb;
    logic [GROUP-1:0] g;
    logic [GROUP-1:0] p;
    logic [GROUP-1:0] s;
    logic [GROUP:0]   c;
    logic             acc;
    logic             term;
    logic             last;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign last      = (k == KW'(N - 1));

    // Each carry is a sum-of-products over the group's g/p and the group carry-in,
    // so no carry depends on a neighbouring carry.
    always_comb begin
        ga   = a_q[int'(k) * GROUP +: GROUP];
        gb   = b_q[int'(k) * GROUP +: GROUP];
        g    = ga & gb;
        p    = ga ^ gb;
        c    = '0;
        acc  = 1'b0;
        term = 1'b0;
        c[0] = carry;
        for (int i = 0; i < GROUP; i++) begin
            term = carry;
            for (int j = 0; j <= i; j++) term = term & p[j];
            acc = term;
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int m = j + 1; m <= i; m++) term = term & p[m];
                acc = acc | term;
            end
            c[i+1] = acc;
        end
        s = p ^ c[GROUP-1:0];
    end

    // Operand capture needs no reset: it is only consumed after an acceptance.
    always_ff @(posedge clk) begin
        if (state == IDLE && in_valid) begin
            a_q <= a;
            b_q <= b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            k     <= '0;
            carry <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
`ifdef CLA_OVERFLOW_EN
            ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        k     <= '0;
                        carry <= cin;
                        state <= CALC;
                    end
                end
                CALC: begin
                    sum[int'(k) * GROUP +: GROUP] <= s;
                    carry <= c[GROUP];
                    k     <= k + KW'(1);
                    if (last) begin
                        cout  <= c[GROUP];
`ifdef CLA_OVERFLOW_EN
                        ovf   <= c[GROUP-1] ^ c[GROUP];
`endif
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cla_group_sequencer.sv
// Directed bench for cla_group_sequencer (defaults WIDTH=16, GROUP=4).
module tb_cla_group_sequencer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        busy;
`ifdef CLA_OVERFLOW_EN
    logic        ovf;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    cla_group_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
`ifdef CLA_OVERFLOW_EN
        ,
        .ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(output int lat);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (out_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic run_op(input logic [15:0] va, input logic [15:0] vb, input logic vc,
                          output int lat);
        in_valid = 1'b1;
        a = va;
        b = vb;
        cin = vc;
        tick();
        in_valid = 1'b0;
        wait_valid(lat);
    endtask

    task automatic finish_op();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
        #2 rst_n = 1'b0;
        #20;
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b want 0", busy); end
        tests_run++;
        if (sum !== 16'h0000) begin tests_failed++; $display("FAIL reset_sum got %h want 0000", sum); end
        tests_run++;
        if (cout !== 1'b0) begin tests_failed++; $display("FAIL reset_cout got %b want 0", cout); end
`ifdef CLA_OVERFLOW_EN
        tests_run++;
        if (ovf !== 1'b0) begin tests_failed++; $display("FAIL reset_ovf got %b want 0", ovf); end
`endif
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        tests_run++;
        if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_carry_chain();
        int lat;
        run_op(16'hFFFF, 16'h0001, 1'b0, lat);
        tests_run++;
        if (lat !== 4) begin tests_failed++; $display("FAIL chain_latency got %0d want 4", lat); end
        tests_run++;
        if (sum !== 16'h0000) begin tests_failed++; $display("FAIL chain_sum got %h want 0000", sum); end
        tests_run++;
        if (cout !== 1'b1) begin tests_failed++; $display("FAIL chain_cout got %b want 1", cout); end
`ifdef CLA_OVERFLOW_EN
        tests_run++;
        if (ovf !== 1'b0) begin tests_failed++; $display("FAIL chain_ovf got %b want 0", ovf); end
`endif
        finish_op();
    endtask

    task automatic test_busy_window();
        int low_cycles;
        out_ready = 1'b1;
        in_valid = 1'b1;
        a = 16'h1234;
        b = 16'h4321;
        cin = 1'b1;
        tick();
        in_valid = 1'b0;
        low_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            if (in_ready) break;
            if (out_valid) begin
                tests_run++;
                if (sum !== 16'h5556) begin tests_failed++; $display("FAIL window_sum got %h want 5556", sum); end
                tests_run++;
                if (cout !== 1'b0) begin tests_failed++; $display("FAIL window_cout got %b want 0", cout); end
            end
            low_cycles++;
            tick();
        end
        out_ready = 1'b0;
        tests_run++;
        if (low_cycles !== 5) begin tests_failed++; $display("FAIL window_in_ready_low got %0d want 5", low_cycles); end
        tests_run++;
        if (sum !== 16'h5556) begin tests_failed++; $display("FAIL window_sum_retained got %h want 5556", sum); end
    endtask

    task automatic test_backpressure();
        int lat;
        run_op(16'h00FF, 16'h0F0F, 1'b0, lat);
        tests_run++;
        if (lat !== 4) begin tests_failed++; $display("FAIL bp_latency got %0d want 4", lat); end
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (sum !== 16'h100E || cout !== 1'b0 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL bp_hold cyc %0d sum %h cout %b ov %b ir %b want 100e 0 1 0",
                         i, sum, cout, out_valid, in_ready);
            end
            tick();
        end
        finish_op();
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_release ov %b ir %b want 0 1", out_valid, in_ready);
        end
        tests_run++;
        if (sum !== 16'h100E) begin tests_failed++; $display("FAIL bp_sum_after got %h want 100e", sum); end
    endtask

    task automatic test_reset_mid_calc();
        int   lat;
        logic seen;
        in_valid = 1'b1;
        a = 16'h1234;
        b = 16'h4321;
        cin = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_ctrl busy %b ov %b want 0 0", busy, out_valid);
        end
        tests_run++;
        if (sum !== 16'h0000 || cout !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_data sum %h cout %b want 0000 0", sum, cout);
        end
        #2 rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        tests_run++;
        if (seen !== 1'b0) begin tests_failed++; $display("FAIL midrst_no_valid got %b want 0", seen); end
        run_op(16'h0001, 16'h0001, 1'b0, lat);
        tests_run++;
        if (lat !== 4 || sum !== 16'h0002 || cout !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_next lat %0d sum %h cout %b want 4 0002 0", lat, sum, cout);
        end
        finish_op();
    endtask

    task automatic test_overflow();
        int lat;
        run_op(16'h7FFF, 16'h0001, 1'b0, lat);
        tests_run++;
        if (sum !== 16'h8000 || cout !== 1'b0) begin
            tests_failed++;
            $display("FAIL ovf1_sum sum %h cout %b want 8000 0", sum, cout);
        end
`ifdef CLA_OVERFLOW_EN
        tests_run++;
        if (ovf !== 1'b1) begin tests_failed++; $display("FAIL ovf1_flag got %b want 1", ovf); end
`endif
        finish_op();
        run_op(16'h8000, 16'h8000, 1'b0, lat);
        tests_run++;
        if (sum !== 16'h0000 || cout !== 1'b1) begin
            tests_failed++;
            $display("FAIL ovf2_sum sum %h cout %b want 0000 1", sum, cout);
        end
`ifdef CLA_OVERFLOW_EN
        tests_run++;
        if (ovf !== 1'b1) begin tests_failed++; $display("FAIL ovf2_flag got %b want 1", ovf); end
`endif
        finish_op();
    endtask

    task automatic test_back_to_back();
        int lat;
        out_ready = 1'b1;
        in_valid = 1'b1;
        a = 16'h0F0F;
        b = 16'h1111;
        cin = 1'b0;
        tick();
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            cin = 1'($urandom);
            tick();
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        tests_run++;
        if (lat !== 4 || sum !== 16'h2020 || cout !== 1'b0) begin
            tests_failed++;
            $display("FAIL toggle_result lat %0d sum %h cout %b want 4 2020 0", lat, sum, cout);
        end
        a = 16'h0003;
        b = 16'h0004;
        cin = 1'b1;
        tick();
        tests_run++;
        if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL toggle_idle ir %b want 1", in_ready); end
        tick();
        tests_run++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL toggle_single_accept ir %b busy %b want 0 1", in_ready, busy);
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        wait_valid(lat);
        tests_run++;
        if (lat !== 4 || sum !== 16'h0008 || cout !== 1'b0) begin
            tests_failed++;
            $display("FAIL toggle_second lat %0d sum %h cout %b want 4 0008 0", lat, sum, cout);
        end
        finish_op();
    endtask

    initial begin
        test_reset();
        test_carry_chain();
        test_busy_window();
        test_backpressure();
        test_reset_mid_calc();
        test_overflow();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/cla_group_sequencer.md
CLA_GROUP_SEQUENCER -- requirements
Module: cla_group_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/sum width in bits.
REQ-002 SHALL have parameter GROUP, default 4, bits per lookahead group; WIDTH SHALL be an integer multiple of GROUP; N = WIDTH/GROUP.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operands and carry-in valid.
REQ-006 SHALL have port in_ready  output  1  block can accept operands.
REQ-007 SHALL have port a  input  WIDTH  operand A.
REQ-008 SHALL have port b  input  WIDTH  operand B.
REQ-009 SHALL have port cin  input  1  carry-in.
REQ-010 SHALL have port out_valid  output  1  result valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port sum  output  WIDTH  registered sum.
REQ-013 SHALL have port cout  output  1  registered carry-out.
REQ-014 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, CALC, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-016 IDLE: on in_valid&&in_ready at an edge, SHALL capture a, b, cin into internal registers, clear group index k to 0, load group carry register with cin, go to CALC.
REQ-017 CALC, each edge, group k (bits k*GROUP..k*GROUP+GROUP-1): per bit generate g=a&b, propagate p=a^b; all GROUP internal carries SHALL be computed by flattened lookahead from the group carry-in (no bit-to-bit ripple); sum bit = p^carry.
REQ-018 CALC SHALL write the group's sum bits into the sum register slice k, load the group carry register with the group carry-out, increment k.
REQ-019 On the edge processing k==N-1, SHALL load cout with the final group carry-out and go to DONE.
REQ-020 Latency: out_valid SHALL rise exactly N clock edges after the acceptance edge (4 for defaults).
REQ-021 DONE: sum/cout SHALL hold stable while out_valid&&!out_ready; on out_ready at an edge SHALL return to IDLE; sum/cout retain value afterwards until next result.
REQ-022 in_valid, a, b, cin SHALL be ignored outside IDLE; operand changes during CALC SHALL NOT affect the result.
REQ-023 Arithmetic: {cout,sum} SHALL equal a+b+cin modulo 2^(WIDTH+1), unsigned.
REQ-024 Throughput: one operation per N+2 cycles minimum (accept, N CALC, DONE handshake); no overlap of operations.

Reset
REQ-025 rst_n low SHALL asynchronously force state IDLE, k=0, carry register 0, sum=0, cout=0, out_valid=0, busy=0, in_ready=1 after release.
REQ-026 Reset asserted mid-CALC or in DONE SHALL discard the in-flight operation; no out_valid afterwards until a new acceptance.

Configuration
REQ-027 Macro CLA_OVERFLOW_EN: when defined, SHALL add port ovf  output  1, registered at the same edge as cout, equal to carry-into-MSB XOR cout (signed two's-complement overflow), reset 0, held with sum.
REQ-028 Without CLA_OVERFLOW_EN, ovf port and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-029 a=0xFFFF, b=0x0001, cin=0 -> out_valid 4 edges after accept, sum=0x0000, cout=1 (ovf=0 if enabled).
REQ-030 a=0x1234, b=0x4321, cin=1 -> sum=0x5556, cout=0; in_ready low for 5 cycles after accept with out_ready=1.
REQ-031 Backpressure: a=0x00FF, b=0x0F0F, cin=0, out_ready low 3 cycles in DONE -> sum=0x100E, cout=0 stable, in_ready=0 until out_ready handshake.
REQ-032 Reset pulse during CALC (k=2) -> out_valid never asserts, sum=0, busy=0; next op a=0x0001,b=0x0001 -> sum=0x0002.
REQ-033 With CLA_OVERFLOW_EN: a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1; a=0x8000, b=0x8000 -> sum=0x0000, cout=1, ovf=1.
REQ-034 Operand toggling during CALC and in_valid held high throughout -> result matches captured operands; exactly one acceptance per IDLE visit.
